// File: rtl/riscv_pkg.sv
// RV32I decode constants: opcode map, immediate formats, instruction field
// positions and a per-opcode operand/writeback usage lookup.
package riscv_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = 6;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_MSB     = 11;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_MSB = 14;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_MSB    = 19;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_MSB    = 24;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_MSB = 31;

  typedef struct packed {
    logic      uses_rs1;
    logic      uses_rs2;
    logic      reg_write;
    imm_type_e imm_type;
  } op_info_t;

  // Which source registers an opcode reads, whether it writes rd, and its immediate format.
  function automatic op_info_t op_info(input logic [6:0] opcode);
    op_info_t info;
    info.uses_rs1  = 1'b0;
    info.uses_rs2  = 1'b0;
    info.reg_write = 1'b0;
    info.imm_type  = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1; info.reg_write = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        info.uses_rs1 = 1'b1; info.reg_write = 1'b1; info.imm_type = IMM_I;
      end
      OPC_STORE: begin
        info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1; info.imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        info.uses_rs1 = 1'b1; info.uses_rs2 = 1'b1; info.imm_type = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        info.reg_write = 1'b1; info.imm_type = IMM_U;
      end
      OPC_JAL: begin
        info.reg_write = 1'b1; info.imm_type = IMM_J;
      end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/imm_decoder.sv
// Combinational RV32I immediate extraction, sign-extended to WIDTH.
// R-type and unknown opcodes yield zero.
module imm_decoder
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [WIDTH-1:0]   imm_o
);

  op_info_t           info;
  logic [INSTR_W-1:0] imm32;

  assign info = op_info(instr_i[OPCODE_MSB:OPCODE_LSB]);

  // Reassemble the scattered immediate bits for each format.
  always_comb begin
    imm32 = '0;
    case (info.imm_type)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = WIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Single-entry decode stage with register scoreboard.
// Holds at most one instruction for execute; stalls on RAW/WAW hazards
// against in-flight writes. Optional feature macro: DECODE_WB_BYPASS_EN
// (writeback data forwarded to operands, clearing the hazard same cycle).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ADDRESS_LENGTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid,
  input  logic [INSTR_W-1:0]        if_instr,
  input  logic [WIDTH-1:0]          if_pc,
  output logic                      id_ready,
  output logic [ADDRESS_LENGTH-1:0] rf_a1,
  output logic [ADDRESS_LENGTH-1:0] rf_a2,
  input  logic [WIDTH-1:0]          rf_rd1,
  input  logic [WIDTH-1:0]          rf_rd2,
  input  logic                      wb_we,
  input  logic [ADDRESS_LENGTH-1:0] wb_rd,
  input  logic [WIDTH-1:0]          wb_data,
  input  logic                      flush,
  input  logic                      sb_clear,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [WIDTH-1:0]          ex_pc,
  output logic [WIDTH-1:0]          ex_rs1_val,
  output logic [WIDTH-1:0]          ex_rs2_val,
  output logic [WIDTH-1:0]          ex_imm,
  output logic [ADDRESS_LENGTH-1:0] ex_rd,
  output logic [6:0]                ex_opcode,
  output logic [2:0]                ex_funct3,
  output logic [6:0]                ex_funct7,
  output logic                      ex_reg_write
);

  localparam int unsigned NUM_REGS = 1 << ADDRESS_LENGTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_REGS-1:0]       busy_q, busy_d;

  logic [ADDRESS_LENGTH-1:0] rs1, rs2, rd;
  op_info_t                  info;
  logic [WIDTH-1:0]          imm, op1, op2;
  logic                      rs1_busy, rs2_busy, rd_busy;
  logic                      hazard, issue;

  logic [WIDTH-1:0]          ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
  logic [ADDRESS_LENGTH-1:0] ex_rd_q;
  logic [6:0]                ex_opcode_q, ex_funct7_q;
  logic [2:0]                ex_funct3_q;
  logic                      ex_reg_write_q;

  assign rs1  = ADDRESS_LENGTH'(if_instr[RS1_MSB:RS1_LSB]);
  assign rs2  = ADDRESS_LENGTH'(if_instr[RS2_MSB:RS2_LSB]);
  assign rd   = ADDRESS_LENGTH'(if_instr[RD_MSB:RD_LSB]);
  assign info = op_info(if_instr[OPCODE_MSB:OPCODE_LSB]);

  assign rf_a1 = rs1;
  assign rf_a2 = rs2;

  imm_decoder #(
    .WIDTH (WIDTH)
  ) u_imm_decoder (
    .instr_i (if_instr),
    .imm_o   (imm)
  );

  // Per-operand hazard lookup and operand source selection.
  always_comb begin
    rs1_busy = busy_q[rs1] && info.uses_rs1;
    rs2_busy = busy_q[rs2] && info.uses_rs2;
    rd_busy  = busy_q[rd]  && info.reg_write;
    op1      = rf_rd1;
    op2      = rf_rd2;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_we && (wb_rd == rs1) && (rs1 != '0)) begin
      rs1_busy = 1'b0;
      op1      = wb_data;
    end
    if (wb_we && (wb_rd == rs2) && (rs2 != '0)) begin
      rs2_busy = 1'b0;
      op2      = wb_data;
    end
`endif
  end

`ifndef DECODE_WB_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign hazard   = if_valid && (rs1_busy || rs2_busy || rd_busy);
  assign ex_valid = (state_q == ST_FULL);
  assign id_ready = rst_n && (!ex_valid || ex_ready) && !hazard && !flush;
  assign issue    = if_valid && id_ready;

  // Occupancy next state: flush empties, issue fills, consumption drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (issue) state_d = ST_FULL;
      ST_FULL: begin
        if (flush)         state_d = ST_EMPTY;
        else if (issue)    state_d = ST_FULL;
        else if (ex_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Scoreboard update; later assignments win: set beats clear, sb_clear beats all.
  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_reg_write_q) busy_d[ex_rd_q] = 1'b0;
    if (issue && info.reg_write && (rd != '0)) busy_d[rd] = 1'b1;
    if (sb_clear) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Execute payload registers, loaded on issue and held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc_q        <= '0;
      ex_rs1_val_q   <= '0;
      ex_rs2_val_q   <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_opcode_q    <= '0;
      ex_funct3_q    <= '0;
      ex_funct7_q    <= '0;
      ex_reg_write_q <= 1'b0;
    end else if (issue) begin
      ex_pc_q        <= if_pc;
      ex_rs1_val_q   <= op1;
      ex_rs2_val_q   <= op2;
      ex_imm_q       <= imm;
      ex_rd_q        <= rd;
      ex_opcode_q    <= if_instr[OPCODE_MSB:OPCODE_LSB];
      ex_funct3_q    <= if_instr[FUNCT3_MSB:FUNCT3_LSB];
      ex_funct7_q    <= if_instr[FUNCT7_MSB:FUNCT7_LSB];
      ex_reg_write_q <= info.reg_write;
    end
  end

  assign ex_pc        = ex_pc_q;
  assign ex_rs1_val   = ex_rs1_val_q;
  assign ex_rs2_val   = ex_rs2_val_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7    = ex_funct7_q;
  assign ex_reg_write = ex_reg_write_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, directed
// handshake/hazard/flush/reset sequences, then randomized traffic against
// an instruction-level reference model.
module tb_decode_stage;

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_UNK   = 7'h0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, sb_clear;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_reg_write;

  logic [31:0] rf [32];
  int n_pass  = 0;
  int n_total = 0;

  assign rf_rd1 = rf[rf_a1];
  assign rf_rd2 = rf[rf_a2];

  always #5 clk = ~clk;

  decode_stage #(.WIDTH(32), .ADDRESS_LENGTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .sb_clear(sb_clear),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_reg_write(ex_reg_write)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Advance one clock; registered outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  endtask

  task automatic idle();
    if_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    flush = 1'b0; sb_clear = 1'b0;
  endtask

  // Instruction encoders: build a word from the architectural immediate value.
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] exp_imm;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [6:0]  exp_op;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        u1, u2, rw;
    logic [31:0] imm;
  } gen_t;

  // Random instruction with its architectural meaning known by construction.
  function automatic gen_t gen_rand();
    gen_t g;
    logic [31:0] v;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    v   = $urandom();
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    f3  = 3'($urandom_range(0, 7));
    g.u1 = 1'b0; g.u2 = 1'b0; g.rw = 1'b0; g.imm = 32'd0;
    case ($urandom_range(0, 9))
      0: begin g.instr = enc_r(v[30] ? 7'h20 : 7'h00, rs2, rs1, f3, rd, OP_OP);
               g.u1 = 1'b1; g.u2 = 1'b1; g.rw = 1'b1; end
      1: begin g.imm = {{20{v[11]}}, v[11:0]}; g.instr = enc_i(g.imm, rs1, f3, rd, OP_IMM);
               g.u1 = 1'b1; g.rw = 1'b1; end
      2: begin g.imm = {{20{v[11]}}, v[11:0]}; g.instr = enc_i(g.imm, rs1, f3, rd, OP_LOAD);
               g.u1 = 1'b1; g.rw = 1'b1; end
      3: begin g.imm = {{20{v[11]}}, v[11:0]}; g.instr = enc_s(g.imm, rs2, rs1, f3, OP_STORE);
               g.u1 = 1'b1; g.u2 = 1'b1; end
      4: begin g.imm = {{19{v[11]}}, v[11:0], 1'b0}; g.instr = enc_b(g.imm, rs2, rs1, f3);
               g.u1 = 1'b1; g.u2 = 1'b1; end
      5: begin g.imm = {v[31:12], 12'd0}; g.instr = enc_u(g.imm, rd, OP_LUI); g.rw = 1'b1; end
      6: begin g.imm = {v[31:12], 12'd0}; g.instr = enc_u(g.imm, rd, OP_AUIPC); g.rw = 1'b1; end
      7: begin g.imm = {{11{v[19]}}, v[19:0], 1'b0}; g.instr = enc_j(g.imm, rd); g.rw = 1'b1; end
      8: begin g.imm = {{20{v[11]}}, v[11:0]}; g.instr = enc_i(g.imm, rs1, 3'd0, rd, OP_JALR);
               g.u1 = 1'b1; g.rw = 1'b1; end
      default: g.instr = {v[31:7], OP_UNK};
    endcase
    return g;
  endfunction

  initial begin
    vec_t tbl [12];
    gen_t g;
    logic [31:0] m_busy, nb;
    logic        m_v, m_rw;
    logic [31:0] m_pc, m_r1, m_r2, m_imm;
    logic [4:0]  m_rd;
    logic [6:0]  m_op;
    logic [4:0]  f1, f2, fd;
    logic        b1, b2, bd, hz, exp_ready, iss;
    logic [31:0] v1, v2;
    int          cand [$];

    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom();
    rf[1] = 32'hDEAD_BEEF;

    tbl[0]  = '{enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd1, OP_IMM),   32'h1000, 32'hFFFF_FFFF, 1'b1, 5'd1,  OP_IMM};
    tbl[1]  = '{enc_i(32'h0000_07FF, 5'd2, 3'd2, 5'd5, OP_LOAD),  32'h1004, 32'h0000_07FF, 1'b1, 5'd5,  OP_LOAD};
    tbl[2]  = '{enc_s(32'hFFFF_FFF8, 5'd3, 5'd4, 3'd2, OP_STORE), 32'h1008, 32'hFFFF_FFF8, 1'b0, 5'd24, OP_STORE};
    tbl[3]  = '{enc_b(32'hFFFF_FFFC, 5'd2, 5'd1, 3'd0),           32'h100C, 32'hFFFF_FFFC, 1'b0, 5'd29, OP_BR};
    tbl[4]  = '{enc_b(32'h0000_0FFE, 5'd2, 5'd1, 3'd1),           32'h1010, 32'h0000_0FFE, 1'b0, 5'd31, OP_BR};
    tbl[5]  = '{enc_u(32'h1234_5000, 5'd6, OP_LUI),               32'h1014, 32'h1234_5000, 1'b1, 5'd6,  OP_LUI};
    tbl[6]  = '{enc_u(32'hFFFF_F000, 5'd7, OP_AUIPC),             32'h1018, 32'hFFFF_F000, 1'b1, 5'd7,  OP_AUIPC};
    tbl[7]  = '{enc_j(32'hFFFF_F800, 5'd1),                       32'h101C, 32'hFFFF_F800, 1'b1, 5'd1,  OP_JAL};
    tbl[8]  = '{enc_i(32'h0000_0004, 5'd5, 3'd0, 5'd1, OP_JALR),  32'h1020, 32'h0000_0004, 1'b1, 5'd1,  OP_JALR};
    tbl[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, OP_OP),      32'h1024, 32'h0000_0000, 1'b1, 5'd8,  OP_OP};
    tbl[10] = '{32'h1234_5F8F,                                    32'h1028, 32'h0000_0000, 1'b0, 5'd31, OP_UNK};
    tbl[11] = '{enc_j(32'h000F_FFFE, 5'd2),                       32'h102C, 32'h000F_FFFE, 1'b1, 5'd2,  OP_JAL};

    // Reset values, observed between edges with a valid instruction offered.
    rst_n = 1'b0; idle(); ex_ready = 1'b1;
    if_valid = 1'b1; if_instr = enc_i(32'd3, 5'd0, 3'd0, 5'd9, OP_IMM); if_pc = 32'h40;
    #12;
    chk("rst_id_ready", 32'(id_ready), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_busy", dut.busy_q, 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_imm", ex_imm, 32'd0);
    if_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Decode vector table.
    for (int i = 0; i < 12; i++) begin
      idle(); sb_clear = 1'b1; tick(); sb_clear = 1'b0;
      if_valid = 1'b1; if_instr = tbl[i].instr; if_pc = tbl[i].pc;
      #1;
      chk($sformatf("vec%0d_id_ready", i), 32'(id_ready), 32'd1);
      tick(); if_valid = 1'b0;
      chk($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("vec%0d_ex_imm", i), ex_imm, tbl[i].exp_imm);
      chk($sformatf("vec%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(tbl[i].exp_rw));
      chk($sformatf("vec%0d_ex_rd", i), 32'(ex_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_ex_opcode", i), 32'(ex_opcode), 32'(tbl[i].exp_op));
      chk($sformatf("vec%0d_ex_pc", i), ex_pc, tbl[i].pc);
    end
    idle(); sb_clear = 1'b1; tick(); sb_clear = 1'b0;

    // addi x1,x0,5 at 0x100.
    if_valid = 1'b1; if_instr = enc_i(32'd5, 5'd0, 3'd0, 5'd1, OP_IMM); if_pc = 32'h100;
    #1; chk("addi_id_ready", 32'(id_ready), 32'd1);
    tick(); if_valid = 1'b0;
    chk("addi_ex_valid", 32'(ex_valid), 32'd1);
    chk("addi_ex_rd", 32'(ex_rd), 32'd1);
    chk("addi_ex_imm", ex_imm, 32'd5);
    chk("addi_ex_pc", ex_pc, 32'h100);
    chk("addi_busy1", 32'(dut.busy_q[1]), 32'd1);

    // Dependent addi x2,x1,1 with the x1 writeback arriving the same cycle.
    if_valid = 1'b1; if_instr = enc_i(32'd1, 5'd1, 3'd0, 5'd2, OP_IMM); if_pc = 32'h104;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_id_ready_bypass", 32'(id_ready), 32'd1);
    tick(); idle();
`else
    chk("raw_id_ready_stall", 32'(id_ready), 32'd0);
    tick(); wb_we = 1'b0;
    #1; chk("raw_id_ready_after_wb", 32'(id_ready), 32'd1);
    chk("raw_busy1_cleared", 32'(dut.busy_q[1]), 32'd0);
    tick(); idle();
`endif
    chk("raw_ex_pc", ex_pc, 32'h104);
    chk("raw_ex_rs1_val", ex_rs1_val, 32'd5);
    chk("raw_busy", dut.busy_q, 32'h0000_0004);
    sb_clear = 1'b1; tick(); sb_clear = 1'b0;

    // Back-pressure: held instruction stays stable while ex_ready is low.
    if_valid = 1'b1; if_instr = enc_i(32'd9, 5'd0, 3'd0, 5'd3, OP_IMM); if_pc = 32'h200;
    tick();
    ex_ready = 1'b0;
    if_instr = enc_i(32'd7, 5'd0, 3'd0, 5'd5, OP_IMM); if_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1; chk($sformatf("stall%0d_id_ready", k), 32'(id_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_ex_valid", k), 32'(ex_valid), 32'd1);
      chk($sformatf("stall%0d_ex_pc", k), ex_pc, 32'h200);
      chk($sformatf("stall%0d_ex_imm", k), ex_imm, 32'd9);
    end
    ex_ready = 1'b1;
    #1; chk("unstall_id_ready", 32'(id_ready), 32'd1);
    tick(); if_valid = 1'b0;
    chk("unstall_ex_pc", ex_pc, 32'h204);
    chk("unstall_ex_imm", ex_imm, 32'd7);

    // Flush of a held instruction writing x3.
    sb_clear = 1'b1; tick(); sb_clear = 1'b0;
    if_valid = 1'b1; if_instr = enc_i(32'd9, 5'd0, 3'd0, 5'd3, OP_IMM); if_pc = 32'h300;
    ex_ready = 1'b0;
    tick();
    chk("flush_pre_busy3", 32'(dut.busy_q[3]), 32'd1);
    if_instr = enc_i(32'd1, 5'd0, 3'd0, 5'd6, OP_IMM); if_pc = 32'h304;
    flush = 1'b1;
    #1; chk("flush_id_ready", 32'(id_ready), 32'd0);
    tick(); idle(); ex_ready = 1'b1;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_busy", dut.busy_q, 32'd0);

    // Branch does not touch the scoreboard; x0 never becomes busy.
    if_valid = 1'b1; if_instr = enc_i(32'd1, 5'd0, 3'd0, 5'd7, OP_IMM); if_pc = 32'h400;
    tick();
    if_instr = enc_b(32'hFFFF_FFFC, 5'd2, 5'd1, 3'd0); if_pc = 32'h404;
    tick();
    chk("beq_ex_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_ex_reg_write", 32'(ex_reg_write), 32'd0);
    chk("beq_busy", dut.busy_q, 32'h0000_0080);
    if_instr = enc_i(32'd1, 5'd0, 3'd0, 5'd0, OP_IMM); if_pc = 32'h408;
    tick();
    chk("x0_ex_rd", 32'(ex_rd), 32'd0);
    chk("x0_busy", dut.busy_q, 32'h0000_0080);

    // Same-cycle set and clear of x4 resolves to set.
    if_instr = enc_i(32'd2, 5'd0, 3'd0, 5'd4, OP_IMM); if_pc = 32'h40C;
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    tick(); wb_we = 1'b0;
    chk("setclr_busy", dut.busy_q, 32'h0000_0090);

    // Asynchronous reset in the middle of a stall.
    ex_ready = 1'b0;
    if_instr = enc_i(32'd3, 5'd0, 3'd0, 5'd9, OP_IMM); if_pc = 32'h410;
    tick();
    #2; rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(ex_valid), 32'd0);
    chk("arst_busy", dut.busy_q, 32'd0);
    chk("arst_id_ready", 32'(id_ready), 32'd0);
    chk("arst_ex_pc", ex_pc, 32'd0);
    idle(); ex_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Randomized traffic against the instruction-level model.
    m_busy = 32'd0; m_v = 1'b0; m_rw = 1'b0; m_rd = 5'd0;
    m_pc = 32'd0; m_r1 = 32'd0; m_r2 = 32'd0; m_imm = 32'd0; m_op = 7'd0;
    for (int c = 0; c < 400; c++) begin
      g = gen_rand();
      if_valid = ($urandom_range(0, 9) < 7);
      if_instr = g.instr;
      if_pc    = $urandom() & 32'hFFFF_FFFC;
      ex_ready = ($urandom_range(0, 9) < 6);
      wb_we = 1'b0; wb_rd = 5'd0; wb_data = $urandom();
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb_we = 1'b1;
        wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      flush    = ($urandom_range(0, 19) == 0);
      sb_clear = ($urandom_range(0, 29) == 0);
      #1;
      f1 = if_instr[19:15]; f2 = if_instr[24:20]; fd = if_instr[11:7];
      b1 = g.u1 && m_busy[f1];
      b2 = g.u2 && m_busy[f2];
      bd = g.rw && m_busy[fd];
      v1 = rf[f1]; v2 = rf[f2];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_we && wb_rd == f1) begin b1 = 1'b0; if (f1 != 5'd0) v1 = wb_data; end
      if (wb_we && wb_rd == f2) begin b2 = 1'b0; if (f2 != 5'd0) v2 = wb_data; end
`endif
      hz = if_valid && (b1 || b2 || bd);
      exp_ready = (!m_v || ex_ready) && !hz && !flush;
      chk($sformatf("rnd%0d_id_ready", c), 32'(id_ready), 32'(exp_ready));
      iss = if_valid && exp_ready;
      nb = m_busy;
      if (wb_we) nb[wb_rd] = 1'b0;
      if (flush && m_v && m_rw) nb[m_rd] = 1'b0;
      if (iss && g.rw) nb[fd] = 1'b1;
      if (sb_clear) nb = 32'd0;
      nb[0] = 1'b0;
      if (flush) m_v = 1'b0;
      else if (iss) begin
        m_v = 1'b1; m_pc = if_pc; m_r1 = v1; m_r2 = v2; m_imm = g.imm;
        m_rw = g.rw; m_rd = fd; m_op = if_instr[6:0];
      end else if (m_v && ex_ready) m_v = 1'b0;
      m_busy = nb;
      tick();
      chk($sformatf("rnd%0d_ex_valid", c), 32'(ex_valid), 32'(m_v));
      chk($sformatf("rnd%0d_busy", c), dut.busy_q, m_busy);
      if (m_v) begin
        chk($sformatf("rnd%0d_ex_pc", c), ex_pc, m_pc);
        chk($sformatf("rnd%0d_ex_rs1_val", c), ex_rs1_val, m_r1);
        chk($sformatf("rnd%0d_ex_rs2_val", c), ex_rs2_val, m_r2);
        chk($sformatf("rnd%0d_ex_imm", c), ex_imm, m_imm);
        chk($sformatf("rnd%0d_ex_rd", c), 32'(ex_rd), 32'(m_rd));
        chk($sformatf("rnd%0d_ex_reg_write", c), 32'(ex_reg_write), 32'(m_rw));
        chk($sformatf("rnd%0d_ex_opcode", c), 32'(ex_opcode), 32'(m_op));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, register/data width; ADDRESS_LENGTH, default 5, register index width.
REQ-002 SHALL have ports, in order:
  clk  in  1  clock, all state on rising edge.
  rst_n  in  1  reset, asynchronous, active-low.
  if_valid  in  1  fetch presents instruction.
  if_instr  in  32  instruction word.
  if_pc  in  WIDTH  instruction address.
  id_ready  out  1  decode accepts this cycle.
  rf_a1, rf_a2  out  ADDRESS_LENGTH  register-file read addresses.
  rf_rd1, rf_rd2  in  WIDTH  register-file read data, combinational.
  wb_we  in  1  writeback write enable.
  wb_rd  in  ADDRESS_LENGTH  writeback destination.
  wb_data  in  WIDTH  writeback data.
  flush  in  1  discard held instruction.
  sb_clear  in  1  clear all scoreboard busy bits.
  ex_valid  out  1  execute-side instruction valid.
  ex_ready  in  1  execute accepts.
  ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  WIDTH  issued PC, operands, sign-extended immediate.
  ex_rd  out  ADDRESS_LENGTH  destination; ex_opcode  out  7; ex_funct3  out  3; ex_funct7  out  7; ex_reg_write  out  1.

Function
REQ-003 SHALL drive rf_a1 = if_instr[19:15], rf_a2 = if_instr[24:20] combinationally.
REQ-004 SHALL hold at most one instruction; two states EMPTY (ex_valid=0) and FULL (ex_valid=1).
REQ-005 SHALL maintain a scoreboard: one busy bit per register 1..2^ADDRESS_LENGTH-1; x0 never busy.
REQ-006 SHALL flag hazard when if_valid and rs1, rs2 (if used by opcode) or rd (if reg_write) is busy.
REQ-007 SHALL drive id_ready = (!ex_valid || ex_ready) && !hazard && !flush.
REQ-008 Issue = if_valid && id_ready; on issue SHALL register all ex_* fields and set ex_valid=1 next cycle; latency 1 cycle.
REQ-009 SHALL set busy[rd] on issue when ex_reg_write and rd != 0.
REQ-010 SHALL clear busy[wb_rd] on wb_we; same-cycle set and clear of the same register SHALL resolve to set.
REQ-011 ex_valid && ex_ready without issue SHALL go FULL->EMPTY; ex_* data SHALL hold while ex_valid && !ex_ready.
REQ-012 flush SHALL clear ex_valid next cycle and clear busy[ex_rd] of the held instruction; no issue that cycle.
REQ-013 sb_clear SHALL clear all busy bits, with priority over REQ-009/010.
REQ-014 ex_reg_write SHALL be 1 for opcodes OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; else 0.
REQ-015 SHALL decode immediates I, S, B, U, J per RV32I, sign-extended to WIDTH; R-type imm = 0.
REQ-016 Unknown opcode SHALL issue with ex_reg_write=0, imm=0.

Reset
REQ-017 rst_n low SHALL asynchronously force EMPTY, all busy bits 0, all ex_* outputs 0.
REQ-018 Reset mid-handshake SHALL drop the held instruction; id_ready SHALL be 0 while rst_n low.

Configuration
REQ-019 With DECODE_WB_BYPASS_EN defined: wb_we && wb_rd == rs SHALL clear that hazard the same cycle and operand SHALL take wb_data instead of rf_rd1/rf_rd2.
REQ-020 Without DECODE_WB_BYPASS_EN: busy clears at the writeback edge; dependent instruction issues one cycle later reading the register file.

Structure
REQ-021 Package riscv_pkg SHALL hold opcode constants/enum, immediate-type enum, instruction field position constants.
REQ-022 Immediate extraction SHALL be sub-module imm_decoder (combinational); scoreboard stays in decode_stage.

Verification
REQ-023 addi x1,x0,5 at pc 0x100, ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_pc=0x100, busy[1]=1.
REQ-024 addi x2,x1,1 while busy[1]; wb_we, wb_rd=1, wb_data=5 -> with macro issues same cycle, ex_rs1_val=5; without, issues next cycle.
REQ-025 ex_ready=0 with FULL, new if_valid -> id_ready=0, ex_* stable for 3 cycles; ex_ready=1 -> new instruction issues.
REQ-026 flush while FULL holding rd=3 -> ex_valid=0 next cycle, busy[3]=0.
REQ-027 beq imm=-4 -> ex_imm=0xFFFFFFFC, ex_reg_write=0, busy unchanged; write to x0 -> busy[0] stays 0.
REQ-028 rst_n low mid-stall -> ex_valid=0, busy all 0 immediately, without clk edge.
